// File: rtl/branch_resolver.sv
// -----------------------------------------------------------------------------
// branch_resolver
//   EX-stage partner of the gshare predictor. Carries each fetched
//   instruction's prediction through the ID and EX slots, compares it with the
//   real outcome in EX, and drives the predictor update, the one-shot flush
//   with its redirect PC, and saturating branch/mispredict counters.
//
// Ports
//   clk, reset          : clock, synchronous active-high reset
//   i_if_valid          : IF holds a real fetched instruction
//   i_if_pc             : PC of the fetched instruction
//   i_if_pred_taken     : predictor "taken" for i_if_pc
//   i_if_pred_target    : predicted target fetched if taken
//   i_hazard            : pipeline stall (same signal the predictor sees)
//   i_ex_is_branch      : EX instruction is a conditional branch
//   i_ex_cond           : EX branch condition (actual taken)
//   i_ex_target         : EX computed branch target
//   o_update            : predictor update strobe
//   o_real_taken        : actual outcome to the predictor
//   o_flush             : squash IF/ID and ID/EX contents
//   o_redirect_pc       : corrected fetch PC, zero unless o_flush
//   o_branch_cnt        : resolved conditional branches (saturating)
//   o_mispred_cnt       : mispredictions of any cause (saturating)
// -----------------------------------------------------------------------------
module branch_resolver #(
    parameter int XLEN  = 32,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_if_valid,
    input  logic [XLEN-1:0]  i_if_pc,
    input  logic             i_if_pred_taken,
    input  logic [XLEN-1:0]  i_if_pred_target,
    input  logic             i_hazard,
    input  logic             i_ex_is_branch,
    input  logic             i_ex_cond,
    input  logic [XLEN-1:0]  i_ex_target,
    output logic             o_update,
    output logic             o_real_taken,
    output logic             o_flush,
    output logic [XLEN-1:0]  o_redirect_pc,
    output logic [CNT_W-1:0] o_branch_cnt,
    output logic [CNT_W-1:0] o_mispred_cnt
);

    typedef struct packed {
        logic            valid;
        logic [XLEN-1:0] pc;
        logic            pred_taken;
        logic [XLEN-1:0] pred_target;
    } slot_t;

    slot_t            r_id;
    slot_t            r_ex;
    logic             r_resolved;
    logic [CNT_W-1:0] r_branch_cnt;
    logic [CNT_W-1:0] r_mispred_cnt;

    logic             w_ev;
    logic             w_actual_taken;
    logic [XLEN-1:0]  w_next_pc;
    logic             w_mispredict;
    logic             w_update;

    // An instruction frozen in EX is evaluated only in its first cycle there;
    // r_resolved masks the remaining stall cycles.
    assign w_ev           = r_ex.valid & ~r_resolved;
    assign w_actual_taken = i_ex_is_branch & i_ex_cond;
    assign w_next_pc      = w_actual_taken ? i_ex_target : r_ex.pc + XLEN'(4);
    assign w_update       = w_ev & i_ex_is_branch;

    // NOTE: every output of a combinational block gets a default before any
    // condition, so no path leaves it unassigned and no latch is inferred.
    always_comb begin
        w_mispredict = 1'b0;
        if (w_ev) begin
            if (i_ex_is_branch) begin
                // Wrong direction, or right "taken" direction with a stale target.
                w_mispredict = (r_ex.pred_taken != i_ex_cond) |
                               (r_ex.pred_taken & i_ex_cond &
                                (r_ex.pred_target != i_ex_target));
            end else begin
                // Predictor aliasing: a non-branch was predicted taken.
                w_mispredict = r_ex.pred_taken;
            end
        end
    end

    assign o_update      = w_update;
    assign o_real_taken  = w_ev & w_actual_taken;
    assign o_flush       = w_mispredict;
    assign o_redirect_pc = w_mispredict ? w_next_pc : '0;
    assign o_branch_cnt  = r_branch_cnt;
    assign o_mispred_cnt = r_mispred_cnt;

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values; EX <= ID relies on this.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_id          <= '0;
            r_ex          <= '0;
            r_resolved    <= 1'b0;
            r_branch_cnt  <= '0;
            r_mispred_cnt <= '0;
        end else begin
            if (w_mispredict) begin
                // Flush beats stall; the instruction now in IF is dropped too.
                r_id.valid <= 1'b0;
                r_ex.valid <= 1'b0;
                r_resolved <= 1'b0;
            end else if (!i_hazard) begin
                r_id       <= '{valid:       i_if_valid,
                                pc:          i_if_pc,
                                pred_taken:  i_if_pred_taken,
                                pred_target: i_if_pred_target};
                r_ex       <= r_id;
                r_resolved <= 1'b0;
            end else begin
                r_resolved <= r_resolved | w_ev;
            end

            if (w_update && (r_branch_cnt != '1)) begin
                r_branch_cnt <= r_branch_cnt + CNT_W'(1);
            end
            if (w_mispredict && (r_mispred_cnt != '1)) begin
                r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_resolver.sv
// -----------------------------------------------------------------------------
// tb_branch_resolver
//   Directed bench for branch_resolver (XLEN=32, CNT_W=4 so counter saturation
//   is reachable quickly). Stimulus pushes the expected EX-cycle response into
//   a queue; a monitor pops and compares whenever update or flush is raised.
// -----------------------------------------------------------------------------
module tb_branch_resolver;

    localparam int XLEN  = 32;
    localparam int CNT_W = 4;

    typedef struct {
        logic            upd;
        logic            rt;
        logic            fl;
        logic [XLEN-1:0] rpc;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             i_if_valid;
    logic [XLEN-1:0]  i_if_pc;
    logic             i_if_pred_taken;
    logic [XLEN-1:0]  i_if_pred_target;
    logic             i_hazard;
    logic             i_ex_is_branch;
    logic             i_ex_cond;
    logic [XLEN-1:0]  i_ex_target;
    logic             o_update;
    logic             o_real_taken;
    logic             o_flush;
    logic [XLEN-1:0]  o_redirect_pc;
    logic [CNT_W-1:0] o_branch_cnt;
    logic [CNT_W-1:0] o_mispred_cnt;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_errors = 0;

    branch_resolver #(.XLEN(XLEN), .CNT_W(CNT_W)) dut (
        .clk              (clk),
        .reset            (reset),
        .i_if_valid       (i_if_valid),
        .i_if_pc          (i_if_pc),
        .i_if_pred_taken  (i_if_pred_taken),
        .i_if_pred_target (i_if_pred_target),
        .i_hazard         (i_hazard),
        .i_ex_is_branch   (i_ex_is_branch),
        .i_ex_cond        (i_ex_cond),
        .i_ex_target      (i_ex_target),
        .o_update         (o_update),
        .o_real_taken     (o_real_taken),
        .o_flush          (o_flush),
        .o_redirect_pc    (o_redirect_pc),
        .o_branch_cnt     (o_branch_cnt),
        .o_mispred_cnt    (o_mispred_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: any update/flush must match the oldest pending expectation.
    always @(negedge clk) begin
        if (o_update === 1'b1 || o_flush === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_output: update=%b flush=%b redirect=0x%08h with nothing expected at %0t",
                         o_update, o_flush, o_redirect_pc, $time);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("update",      32'(o_update),     32'(e.upd));
                check("real_taken",  32'(o_real_taken), 32'(e.rt));
                check("flush",       32'(o_flush),      32'(e.fl));
                check("redirect_pc", o_redirect_pc,     e.rpc);
            end
        end
    end

    task automatic clear_if();
        i_if_valid       = 1'b0;
        i_if_pc          = '0;
        i_if_pred_taken  = 1'b0;
        i_if_pred_target = '0;
    endtask

    task automatic clear_ex();
        i_ex_is_branch = 1'b0;
        i_ex_cond      = 1'b0;
        i_ex_target    = '0;
    endtask

    // Sends one instruction through IF->ID->EX, holds it in EX for 'hold'
    // cycles via i_hazard, and queues the expected EX response. When a flush
    // is expected, a predicted-taken junk fetch sits in IF during that cycle;
    // if it were captured it would surface later as an unexpected flush.
    task automatic run_instr(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                             input logic br, input logic cond, input logic [31:0] tgt,
                             input int hold,
                             input logic e_upd, input logic e_rt, input logic e_fl,
                             input logic [31:0] e_rpc);
        i_if_valid       = 1'b1;
        i_if_pc          = pc;
        i_if_pred_taken  = pt;
        i_if_pred_target = ptgt;
        @(posedge clk); #1;
        clear_if();
        @(posedge clk); #1;
        if (e_upd || e_fl) exp_q.push_back('{e_upd, e_rt, e_fl, e_rpc});
        i_ex_is_branch = br;
        i_ex_cond      = cond;
        i_ex_target    = tgt;
        if (e_fl) begin
            i_if_valid       = 1'b1;
            i_if_pc          = 32'h000D_EAD0;
            i_if_pred_taken  = 1'b1;
            i_if_pred_target = 32'h000B_EEF0;
        end
        i_hazard = (hold > 1);
        for (int k = 1; k <= hold; k++) begin
            @(posedge clk); #1;
            clear_if();
            if (k >= hold - 1) i_hazard = 1'b0;
        end
        // EX now holds a bubble (or was flushed) while the old EX inputs linger.
        @(posedge clk); #1;
        clear_ex();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        reset    = 1'b1;
        i_hazard = 1'b0;
        clear_if();
        clear_ex();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("idle_update",  32'(o_update),      32'd0);
        check("idle_rtaken",  32'(o_real_taken),  32'd0);
        check("idle_flush",   32'(o_flush),       32'd0);
        check("idle_redir",   o_redirect_pc,      32'd0);
        check("idle_brcnt",   32'(o_branch_cnt),  32'd0);
        check("idle_miscnt",  32'(o_mispred_cnt), 32'd0);

        // Predicted not-taken, actually taken.
        run_instr(32'h100, 1'b0, 32'h0,   1'b1, 1'b1, 32'h140, 1, 1'b1, 1'b1, 1'b1, 32'h140);
        check("t1_brcnt",  32'(o_branch_cnt),  32'd1);
        check("t1_miscnt", 32'(o_mispred_cnt), 32'd1);

        // Correct taken prediction with matching target.
        run_instr(32'h200, 1'b1, 32'h180, 1'b1, 1'b1, 32'h180, 1, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t2_brcnt",  32'(o_branch_cnt),  32'd2);
        check("t2_miscnt", 32'(o_mispred_cnt), 32'd1);

        // Predicted taken, not taken, stalled 3 cycles in EX.
        run_instr(32'h200, 1'b1, 32'h180, 1'b1, 1'b0, 32'h180, 3, 1'b1, 1'b0, 1'b1, 32'h204);
        check("t3_brcnt",  32'(o_branch_cnt),  32'd3);
        check("t3_miscnt", 32'(o_mispred_cnt), 32'd2);

        // Correct prediction stalled 3 cycles: a single update only.
        run_instr(32'h200, 1'b1, 32'h180, 1'b1, 1'b1, 32'h180, 3, 1'b1, 1'b1, 1'b0, 32'h0);
        check("t4_brcnt",  32'(o_branch_cnt),  32'd4);
        check("t4_miscnt", 32'(o_mispred_cnt), 32'd2);

        // Aliasing: non-branch predicted taken.
        run_instr(32'h300, 1'b1, 32'h380, 1'b0, 1'b0, 32'h0,   1, 1'b0, 1'b0, 1'b1, 32'h304);
        check("t5_brcnt",  32'(o_branch_cnt),  32'd4);
        check("t5_miscnt", 32'(o_mispred_cnt), 32'd3);

        // Right direction, wrong target.
        run_instr(32'h400, 1'b1, 32'h480, 1'b1, 1'b1, 32'h440, 1, 1'b1, 1'b1, 1'b1, 32'h440);
        check("t6_brcnt",  32'(o_branch_cnt),  32'd5);
        check("t6_miscnt", 32'(o_mispred_cnt), 32'd4);

        // Non-branch, not predicted taken: silent even with ex_cond high.
        run_instr(32'h500, 1'b0, 32'h0,   1'b0, 1'b1, 32'h540, 1, 1'b0, 1'b0, 1'b0, 32'h0);
        check("t7_brcnt",  32'(o_branch_cnt),  32'd5);
        check("t7_miscnt", 32'(o_mispred_cnt), 32'd4);

        // pc+4 wraps modulo 2^32.
        run_instr(32'hFFFF_FFFC, 1'b1, 32'h10, 1'b0, 1'b0, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'h0);
        check("t8_brcnt",  32'(o_branch_cnt),  32'd5);
        check("t8_miscnt", 32'(o_mispred_cnt), 32'd5);

        // Ten more mispredicted branches bring both counters to all-ones.
        for (int i = 0; i < 10; i++) begin
            run_instr(32'h800 + 32'(i * 16), 1'b0, 32'h0, 1'b1, 1'b1, 32'h840 + 32'(i * 16), 1,
                      1'b1, 1'b1, 1'b1, 32'h840 + 32'(i * 16));
        end
        check("sat_brcnt",  32'(o_branch_cnt),  32'd15);
        check("sat_miscnt", 32'(o_mispred_cnt), 32'd15);
        for (int i = 0; i < 2; i++) begin
            run_instr(32'h900 + 32'(i * 16), 1'b0, 32'h0, 1'b1, 1'b1, 32'h940 + 32'(i * 16), 1,
                      1'b1, 1'b1, 1'b1, 32'h940 + 32'(i * 16));
        end
        check("hold_brcnt",  32'(o_branch_cnt),  32'd15);
        check("hold_miscnt", 32'(o_mispred_cnt), 32'd15);

        // Reset asserted during a stalled flush cycle.
        i_if_valid       = 1'b1;
        i_if_pc          = 32'h700;
        i_if_pred_taken  = 1'b0;
        i_if_pred_target = 32'h0;
        @(posedge clk); #1;
        clear_if();
        @(posedge clk); #1;
        exp_q.push_back('{1'b1, 1'b1, 1'b1, 32'h740});
        i_ex_is_branch = 1'b1;
        i_ex_cond      = 1'b1;
        i_ex_target    = 32'h740;
        i_hazard       = 1'b1;
        reset          = 1'b1;
        @(posedge clk); #1;
        reset    = 1'b0;
        i_hazard = 1'b0;
        check("rst_update", 32'(o_update),      32'd0);
        check("rst_rtaken", 32'(o_real_taken),  32'd0);
        check("rst_flush",  32'(o_flush),       32'd0);
        check("rst_redir",  o_redirect_pc,      32'd0);
        check("rst_brcnt",  32'(o_branch_cnt),  32'd0);
        check("rst_miscnt", 32'(o_mispred_cnt), 32'd0);
        clear_ex();
        repeat (3) @(posedge clk);
        #1;
        check("queue_drained", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
